// File: rtl/reset_ctrl.sv
// Board reset sequencer: debounced button, minimum assert time and staggered
// per-domain release. Every register powers up at its reset value.
module reset_ctrl #(
  parameter int POR_CYCLES      = 32,
  parameter int NUM_DOMAINS     = 2,
  parameter int STAGGER_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   btn_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   ready_o,
  output logic                   btn_press_o
);

  localparam int CNT_W = (POR_CYCLES      > 1) ? $clog2(POR_CYCLES)      : 1;
  localparam int S_W   = (STAGGER_CYCLES  > 1) ? $clog2(STAGGER_CYCLES)  : 1;
  localparam int K_W   = (NUM_DOMAINS     > 1) ? $clog2(NUM_DOMAINS)     : 1;
  localparam int DC_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [S_W-1:0]   S_LAST   = S_W'(STAGGER_CYCLES - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(NUM_DOMAINS - 1);
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Button front end: normalise to pressed = 1, synchronise, debounce.
  // ---------------------------------------------------------------------
  logic            btn_pressed;
  logic            sync1_q = 1'b0;
  logic            sync2_q = 1'b0;
  logic            db_q    = 1'b0;
  logic            db_d;
  logic [DC_W-1:0] dc_q    = '0;
  logic [DC_W-1:0] dc_d;
  logic            press_q = 1'b0;
  logic            press_d;

  assign btn_pressed = (BTN_ACTIVE_LOW != 0) ? ~btn_i : btn_i;

  always_comb begin
    db_d    = db_q;
    dc_d    = '0;
    press_d = 1'b0;
    if (sync2_q != db_q) begin
      if (dc_q == DC_LAST) begin
        db_d    = sync2_q;
        press_d = sync2_q;
      end else begin
        dc_d = dc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      dc_q    <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_pressed;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dc_q    <= dc_d;
      press_q <= press_d;
    end
  end

  // ---------------------------------------------------------------------
  // Release sequencer. Outputs are registered; the FSM only looks at the
  // registered debounced level, so nothing reaches rst_o combinationally.
  // ---------------------------------------------------------------------
  logic                   req;
  state_t                 state_q = ST_ASSERT;
  state_t                 state_d;
  logic [CNT_W-1:0]       cnt_q   = '0;
  logic [CNT_W-1:0]       cnt_d;
  logic [S_W-1:0]         s_q     = '0;
  logic [S_W-1:0]         s_d;
  logic [K_W-1:0]         k_q     = '0;
  logic [K_W-1:0]         k_d;
  logic [NUM_DOMAINS-1:0] rst_q   = '1;
  logic [NUM_DOMAINS-1:0] rst_d;
  logic                   ready_q = 1'b0;
  logic                   ready_d;

  assign req = db_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    k_d     = k_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    case (state_q)
      ST_ASSERT: begin
        rst_d   = '1;
        ready_d = 1'b0;
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          rst_d[0] = 1'b0;
          cnt_d    = '0;
          if (NUM_DOMAINS == 1) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
            k_d     = K_W'(1);
            s_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (req) begin
          state_d = ST_ASSERT;
          rst_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end else if (s_q == S_LAST) begin
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (k_q == K_W'(i)) rst_d[i] = 1'b0;
          end
          s_d = '0;
          if (k_q == K_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          s_d = s_q + 1'b1;
        end
      end

      ST_RUN: begin
        rst_d   = '0;
        ready_d = 1'b1;
        if (req) begin
          state_d = ST_ASSERT;
          rst_d   = '1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        rst_d   = '1;
        ready_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      s_q     <= '0;
      k_q     <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      k_q     <= k_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign rst_o       = rst_q;
  assign ready_o     = ready_q;
  assign btn_press_o = press_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: per-cycle reference model plus directed tables and
// sequences on a 3-domain, a single-domain and an active-high-button instance.
module tb_reset_ctrl;

  localparam int POR  = 32;
  localparam int N    = 3;
  localparam int STAG = 4;
  localparam int DEB  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i = 1'b1;
  logic         btn_i   = 1'b1;
  logic         btn_one = 1'b1;
  logic         btn_ah  = 1'b0;
  logic [N-1:0] rst_o;
  logic         ready_o, press_o;
  logic [0:0]   rst_one;
  logic         ready_one, press_one;
  logic [N-1:0] rst_ah;
  logic         ready_ah, press_ah;

  reset_ctrl #(.POR_CYCLES(POR), .NUM_DOMAINS(N), .STAGGER_CYCLES(STAG),
               .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1)) u_dut (
    .clk(clk), .reset_i(reset_i), .btn_i(btn_i),
    .rst_o(rst_o), .ready_o(ready_o), .btn_press_o(press_o));

  reset_ctrl #(.POR_CYCLES(POR), .NUM_DOMAINS(1), .STAGGER_CYCLES(1),
               .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1)) u_one (
    .clk(clk), .reset_i(reset_i), .btn_i(btn_one),
    .rst_o(rst_one), .ready_o(ready_one), .btn_press_o(press_one));

  reset_ctrl #(.POR_CYCLES(POR), .NUM_DOMAINS(N), .STAGGER_CYCLES(STAG),
               .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(0)) u_ah (
    .clk(clk), .reset_i(reset_i), .btn_i(btn_ah),
    .rst_o(rst_ah), .ready_o(ready_ah), .btn_press_o(press_ah));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Domain k is held while fewer than POR + k*STAG quiet cycles (no request)
  // have elapsed; the debounced level flips after DEB consecutive opposite
  // samples of the synchronised pin.
  typedef logic [N+1:0] exp_t;
  exp_t exp_q[$];
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_db = 1'b0;
  logic m_hist[$];
  int   quiet = 0;

  always @(posedge clk) begin
    logic         old_db, flip, rise, e_rdy;
    logic [N-1:0] e_rst;
    old_db = m_db;
    rise   = 1'b0;
    if (reset_i) begin
      quiet = 0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_db = 1'b0;
      m_hist.delete();
    end else begin
      if (old_db) quiet = 0;
      else if (quiet < 1000000) quiet++;
      m_hist.push_back(m_s2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      flip = (m_hist.size() == DEB);
      foreach (m_hist[i]) if (m_hist[i] == old_db) flip = 1'b0;
      if (flip) begin
        m_db = ~old_db;
        rise = m_db;
        m_hist.delete();
      end
      m_s2 = m_s1;
      m_s1 = ~btn_i;
    end
    for (int k = 0; k < N; k++) e_rst[k] = (quiet < POR + k * STAG);
    e_rdy = (quiet >= POR + (N - 1) * STAG);
    exp_q.push_back({e_rst, e_rdy, rise});
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model_outputs", {27'd0, rst_o, ready_o, press_o}, {27'd0, e});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, ready_o, 1);
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  typedef struct {
    int   low_cycles;
    int   exp_pulses;
    logic exp_any_rst;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int f0, f1, f2, fr, f1r, f1d, far, pulses, n_idx, fa;
    logic any_rst;

    vecs[0] = '{10,  0, 1'b0};
    vecs[1] = '{15,  0, 1'b0};
    vecs[2] = '{16,  1, 1'b1};
    vecs[3] = '{100, 1, 1'b1};
    vecs[4] = '{1,   0, 1'b0};

    // Power-up: reset_i high for the first edge (E), then released.
    @(negedge clk);
    reset_i = 1'b0;
    check("reset_rst", rst_o, 3'b111);
    check("reset_ready", ready_o, 0);
    check("reset_press", press_o, 0);
    check("reset_one_rst", rst_one, 1);
    f0 = -1; f1 = -1; f2 = -1; fr = -1; f1r = -1; f1d = -1; far = -1; pulses = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (!rst_o[0] && f0 < 0) f0 = n;
      if (!rst_o[1] && f1 < 0) f1 = n;
      if (!rst_o[2] && f2 < 0) f2 = n;
      if (ready_o && fr < 0) fr = n;
      if (!rst_one[0] && f1d < 0) f1d = n;
      if (ready_one && f1r < 0) f1r = n;
      if (ready_ah && far < 0) far = n;
      pulses += int'(press_o);
    end
    check("pu_rst0_edge", f0, 32);
    check("pu_rst1_edge", f1, 36);
    check("pu_rst2_edge", f2, 40);
    check("pu_ready_edge", fr, 40);
    check("pu_no_press", pulses, 0);
    check("one_rst_edge", f1d, 32);
    check("one_ready_edge", f1r, 32);
    check("ah_idle_ready_edge", far, 40);

    // Table: button low for N cycles while in RUN.
    foreach (vecs[v]) begin
      pulses = 0;
      any_rst = 1'b0;
      btn_i = 1'b0;
      repeat (vecs[v].low_cycles) begin
        @(negedge clk);
        pulses += int'(press_o);
        any_rst |= (rst_o == 3'b111);
      end
      btn_i = 1'b1;
      repeat (25) begin
        @(negedge clk);
        pulses += int'(press_o);
        any_rst |= (rst_o == 3'b111);
      end
      check($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
      check($sformatf("vec%0d_reset", v), any_rst, vecs[v].exp_any_rst);
      wait_ready($sformatf("vec%0d_ready", v));
    end

    // Abort mid-release: press qualifies between rst_o[0] and rst_o[1].
    pulse_reset();
    repeat (16) @(negedge clk);
    btn_i = 1'b0;
    fa = -1;
    for (int n = 17; n <= 100; n++) begin
      @(negedge clk);
      if (n == 33) check("abort_pre", rst_o, 3'b110);
      if (n == 34) check("abort_press", press_o, 1);
      if (n == 35) check("abort_reassert", {rst_o, ready_o}, 4'b1110);
      if (n == 40) btn_i = 1'b1;
      if (n > 35 && fa < 0 && !rst_o[0]) fa = n;
    end
    check("abort_restart_edge", fa, 90);
    wait_ready("abort_ready");

    // Active-high button: 40 cycles pressed -> one pulse, full re-sequence.
    pulses = 0;
    any_rst = 1'b0;
    btn_ah = 1'b1;
    repeat (40) begin
      @(negedge clk);
      pulses += int'(press_ah);
      any_rst |= (rst_ah == 3'b111);
    end
    btn_ah = 1'b0;
    repeat (150) begin
      @(negedge clk);
      pulses += int'(press_ah);
      any_rst |= (rst_ah == 3'b111);
    end
    check("ah_pulses", pulses, 1);
    check("ah_reset_seen", any_rst, 1);
    check("ah_ready_again", ready_ah, 1);

    // Random bursts, glitches and occasional reset_i pulses.
    for (int r = 0; r < 30; r++) begin
      btn_i = 1'b0;
      n_idx = $urandom_range(1, 30);
      repeat (n_idx) @(negedge clk);
      btn_i = 1'b1;
      n_idx = $urandom_range(1, 60);
      repeat (n_idx) @(negedge clk);
      if ($urandom_range(0, 7) == 0) pulse_reset();
    end
    btn_i = 1'b1;
    repeat (120) @(negedge clk);
    wait_ready("final_ready");
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
